// File: rtl/e603_gnrl_clkgate_ctrl_if.sv
// Per-channel activity, wake handshake and gate-cell control bundle for the clock-gating controller.
// master = core/bus units side, slave = gating controller side.
interface e603_gnrl_clkgate_ctrl_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] cfg_gate_allow;
  logic [CH_NUM-1:0] busy;
  logic [CH_NUM-1:0] wake_req;
  logic [CH_NUM-1:0] wake_ack;
  logic [CH_NUM-1:0] cg_en;
  logic [CH_NUM-1:0] cg_bypass;
  logic [CH_NUM-1:0] gated;

  modport master (
    output cfg_gate_allow, busy, wake_req,
    input  wake_ack, cg_en, cg_bypass, gated
  );

  modport slave (
    input  cfg_gate_allow, busy, wake_req,
    output wake_ack, cg_en, cg_bypass, gated
  );
endinterface

// File: rtl/e603_gnrl_clkgate_ctrl.sv
// N-channel automatic clock-gating controller: gates each domain after IDLE_CYC idle cycles, wakes on request.
// Optional per-channel gated-cycle statistics are enabled by defining E603_CG_STATS_EN.
module e603_gnrl_clkgate_ctrl #(
  parameter int CH_NUM   = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_LAT = 2,
  parameter int CNT_W    = 5
) (
  e603_gnrl_clkgate_ctrl_if.slave cg,
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_bypass
`ifdef E603_CG_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [CH_NUM*32-1:0]   gated_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } cg_state_e;

  logic [CH_NUM-1:0] cg_en_w;
  logic [CH_NUM-1:0] gated_w;
  logic [CH_NUM-1:0] wake_ack_w;
  logic [CH_NUM-1:0] cg_bypass_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      cg_state_e        state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             ack_reg, ack_next;
      logic             idle;
      logic             wake_cond;

      assign idle      = ~cg.busy[gi] & ~cg.wake_req[gi] & cg.cfg_gate_allow[gi] & ~cfg_bypass;
      // Losing gating permission while gated behaves like a wake request.
      assign wake_cond = cg.busy[gi] | cg.wake_req[gi] | ~cg.cfg_gate_allow[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= ST_RUN;
          cnt_reg   <= '0;
          ack_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          ack_reg   <= ack_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;
        if (cfg_bypass) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          ack_next   = cg.wake_req[gi];
        end else begin
          case (state_reg)
            ST_RUN: begin
              ack_next = cg.wake_req[gi];
              if (idle) begin
                if (cnt_reg == CNT_W'(IDLE_CYC - 1)) begin
                  state_next = ST_GATED;
                  cnt_next   = '0;
                end else begin
                  cnt_next = cnt_reg + 1'b1;
                end
              end else begin
                cnt_next = '0;
              end
            end
            ST_GATED: begin
              if (wake_cond) begin
                if (WAKE_LAT == 0) begin
                  state_next = ST_RUN;
                  cnt_next   = '0;
                  ack_next   = cg.wake_req[gi];
                end else begin
                  state_next = ST_WAKE;
                  cnt_next   = CNT_W'(1);
                end
              end
            end
            ST_WAKE: begin
              // Settle window: the clock is already enabled, ack only once it has counted out.
              if (cnt_reg == CNT_W'(WAKE_LAT)) begin
                state_next = ST_RUN;
                cnt_next   = '0;
                ack_next   = cg.wake_req[gi];
              end else begin
                cnt_next = cnt_reg + 1'b1;
              end
            end
            default: begin
              state_next = ST_RUN;
              cnt_next   = '0;
            end
          endcase
        end
      end

      assign cg_en_w[gi]    = (state_reg != ST_GATED);
      assign gated_w[gi]    = (state_reg == ST_GATED);
      assign wake_ack_w[gi] = ack_reg;

`ifdef E603_CG_STATS_EN
      logic [31:0] gated_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
          gated_cnt_reg <= '0;
        end else if ((state_reg == ST_GATED) && (gated_cnt_reg != 32'hFFFF_FFFF)) begin
          gated_cnt_reg <= gated_cnt_reg + 32'd1;
        end
      end

      assign gated_cnt[gi*32 +: 32] = gated_cnt_reg;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cg_bypass_reg <= '0;
    end else begin
      cg_bypass_reg <= {CH_NUM{cfg_bypass}};
    end
  end

  assign cg.cg_en     = cg_en_w;
  assign cg.gated     = gated_w;
  assign cg.wake_ack  = wake_ack_w;
  assign cg.cg_bypass = cg_bypass_reg;

endmodule

// File: tb/tb_e603_gnrl_clkgate_ctrl.sv
// Bench for e603_gnrl_clkgate_ctrl: one instance with WAKE_LAT=2 and one with WAKE_LAT=0 on shared stimulus,
// checked every cycle against an abstract channel model plus hand-computed cycle expectations.
module tb_e603_gnrl_clkgate_ctrl;
  localparam int CH   = 4;
  localparam int IDLE = 16;

  logic clk = 1'b0;
  logic rst;
  logic cfg_bypass;
  logic [CH-1:0] busy, wake_req, allow;
`ifdef E603_CG_STATS_EN
  logic stats_clr;
  logic [CH*32-1:0] gcnt2, gcnt0;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  e603_gnrl_clkgate_ctrl_if #(.CH_NUM(CH)) if2 ();
  e603_gnrl_clkgate_ctrl_if #(.CH_NUM(CH)) if0 ();

  assign if2.busy = busy;  assign if2.wake_req = wake_req;  assign if2.cfg_gate_allow = allow;
  assign if0.busy = busy;  assign if0.wake_req = wake_req;  assign if0.cfg_gate_allow = allow;

  e603_gnrl_clkgate_ctrl #(.CH_NUM(CH), .IDLE_CYC(IDLE), .WAKE_LAT(2), .CNT_W(5)) dut (
    .cg(if2), .clk(clk), .rst(rst), .cfg_bypass(cfg_bypass)
`ifdef E603_CG_STATS_EN
    , .stats_clr(stats_clr), .gated_cnt(gcnt2)
`endif
  );

  e603_gnrl_clkgate_ctrl #(.CH_NUM(CH), .IDLE_CYC(IDLE), .WAKE_LAT(0), .CNT_W(5)) dut0 (
    .cg(if0), .clk(clk), .rst(rst), .cfg_bypass(cfg_bypass)
`ifdef E603_CG_STATS_EN
    , .stats_clr(stats_clr), .gated_cnt(gcnt0)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp_v);
    end
  endtask

  // Model: per channel an idle streak, a gated flag and a remaining-settle countdown.
  int          m_idle [2][CH];
  bit          m_gat  [2][CH];
  int          m_wl   [2][CH];
  bit          m_ack  [2][CH];
  logic [31:0] m_gc   [2][CH];
  bit          m_cgb;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int lat;
      lat = (k == 0) ? 2 : 0;
      for (int c = 0; c < CH; c++) begin
        if (rst) begin
          m_idle[k][c] = 0; m_gat[k][c] = 0; m_wl[k][c] = 0; m_ack[k][c] = 0; m_gc[k][c] = 0;
        end else begin
`ifdef E603_CG_STATS_EN
          if (stats_clr) m_gc[k][c] = 0;
          else if (m_gat[k][c] && m_gc[k][c] != 32'hFFFF_FFFF) m_gc[k][c] = m_gc[k][c] + 1;
`endif
          m_ack[k][c] = 0;
          if (cfg_bypass) begin
            m_gat[k][c] = 0; m_wl[k][c] = 0; m_idle[k][c] = 0; m_ack[k][c] = wake_req[c];
          end else if (m_gat[k][c]) begin
            if (busy[c] || wake_req[c] || !allow[c]) begin
              m_gat[k][c] = 0;
              m_idle[k][c] = 0;
              if (lat == 0) m_ack[k][c] = wake_req[c];
              else m_wl[k][c] = lat;
            end
          end else if (m_wl[k][c] > 0) begin
            m_wl[k][c] = m_wl[k][c] - 1;
            if (m_wl[k][c] == 0) m_ack[k][c] = wake_req[c];
          end else begin
            m_ack[k][c] = wake_req[c];
            if (!busy[c] && !wake_req[c] && allow[c]) begin
              m_idle[k][c] = m_idle[k][c] + 1;
              if (m_idle[k][c] == IDLE) begin
                m_gat[k][c] = 1; m_idle[k][c] = 0;
              end
            end else begin
              m_idle[k][c] = 0;
            end
          end
        end
      end
    end
    m_cgb = rst ? 1'b0 : cfg_bypass;
    if (rst) m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      logic [CH-1:0] e_en [2];
      logic [CH-1:0] e_g  [2];
      logic [CH-1:0] e_a  [2];
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < CH; c++) begin
          e_en[k][c] = !m_gat[k][c];
          e_g[k][c]  = m_gat[k][c];
          e_a[k][c]  = m_ack[k][c];
        end
      chk("m2_cg_en", 32'(if2.cg_en), 32'(e_en[0]));
      chk("m2_gated", 32'(if2.gated), 32'(e_g[0]));
      chk("m2_ack",   32'(if2.wake_ack), 32'(e_a[0]));
      chk("m2_byp",   32'(if2.cg_bypass), 32'({CH{m_cgb}}));
      chk("m0_cg_en", 32'(if0.cg_en), 32'(e_en[1]));
      chk("m0_gated", 32'(if0.gated), 32'(e_g[1]));
      chk("m0_ack",   32'(if0.wake_ack), 32'(e_a[1]));
      chk("m0_byp",   32'(if0.cg_bypass), 32'({CH{m_cgb}}));
`ifdef E603_CG_STATS_EN
      for (int c = 0; c < CH; c++) begin
        chk("m2_gcnt", gcnt2[c*32 +: 32], m_gc[0][c]);
        chk("m0_gcnt", gcnt0[c*32 +: 32], m_gc[1][c]);
      end
`endif
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_bypass = 1'b0; busy = 4'hF; wake_req = 4'h0; allow = 4'hF;
`ifdef E603_CG_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("t1_cg_en", 32'(if2.cg_en), 32'hF);
    chk("t1_gated", 32'(if2.gated), 32'h0);
    chk("t1_ack",   32'(if2.wake_ack), 32'h0);
    chk("t1_byp",   32'(if2.cg_bypass), 32'h0);
    chk("t1_cg_en0", 32'(if0.cg_en), 32'hF);
    rst = 1'b0;
    busy = 4'b1100;

    step_to(10); busy[1] = 1'b1;
    step_to(11); busy[1] = 1'b0;
    step_to(15); chk("t2_ch0_pre",  32'(if2.cg_en[0]), 32'h1);
    step_to(16); chk("t2_ch0_off",  32'(if2.cg_en[0]), 32'h0);
                 chk("t2_ch0_gtd",  32'(if2.gated[0]), 32'h1);
    step_to(26); chk("t2_ch1_pre",  32'(if2.cg_en[1]), 32'h1);
    step_to(27); chk("t2_ch1_off",  32'(if2.cg_en[1]), 32'h0);
                 chk("t2_ch1_gtd",  32'(if2.gated[1]), 32'h1);

    step_to(30); chk("t3_l0_pre", 32'(if0.cg_en[1]), 32'h0);
                 wake_req[1] = 1'b1;
    step_to(31); chk("t3_en",     32'(if2.cg_en[1]), 32'h1);
                 chk("t3_gtd",    32'(if2.gated[1]), 32'h0);
                 chk("t3_ack31",  32'(if2.wake_ack[1]), 32'h0);
                 chk("t3_l0_en",  32'(if0.cg_en[1]), 32'h1);
                 chk("t3_l0_ack", 32'(if0.wake_ack[1]), 32'h1);
    step_to(32); chk("t3_ack32",  32'(if2.wake_ack[1]), 32'h0);
    step_to(33); chk("t3_ack33",  32'(if2.wake_ack[1]), 32'h1);
                 wake_req[1] = 1'b0;
    step_to(34); chk("t3_ack34",  32'(if2.wake_ack[1]), 32'h0);

    step_to(40); busy[2] = 1'b0;
    step_to(55); chk("t4_en55", 32'(if2.cg_en[2]), 32'h1);
                 wake_req[2] = 1'b1;
    step_to(56); chk("t4_en56",  32'(if2.cg_en[2]), 32'h1);
                 chk("t4_ack56", 32'(if2.wake_ack[2]), 32'h1);
                 wake_req[2] = 1'b0; busy[2] = 1'b1;
    step_to(57); chk("t4_en57",  32'(if2.cg_en[2]), 32'h1);
                 chk("t4_ack57", 32'(if2.wake_ack[2]), 32'h0);

    step_to(60); busy[3] = 1'b0;
    step_to(75); chk("t5_ch3_pre", 32'(if2.cg_en[3]), 32'h1);
    step_to(76); chk("t5_ch3_gtd", 32'(if2.gated[3]), 32'h1);
    step_to(78); cfg_bypass = 1'b1; wake_req[0] = 1'b1;
    step_to(79); chk("t5_en",   32'(if2.cg_en), 32'hF);
                 chk("t5_byp",  32'(if2.cg_bypass), 32'hF);
                 chk("t5_gtd",  32'(if2.gated), 32'h0);
                 chk("t5_ack0", 32'(if2.wake_ack[0]), 32'h1);
`ifdef E603_CG_STATS_EN
                 chk("t6_gcnt63", gcnt2[31:0], 32'd63);
`endif
                 wake_req[0] = 1'b0;
    step_to(80); cfg_bypass = 1'b0; allow[3] = 1'b0; busy = 4'b0100;
    step_to(81); chk("t5_byp_off", 32'(if2.cg_bypass), 32'h0);
    step_to(96); chk("t5_gtd96",   32'(if2.gated), 32'h3);
    step_to(100); allow[0] = 1'b0;
    step_to(101); chk("t5_allow_en",  32'(if2.cg_en[0]), 32'h1);
                  chk("t5_allow_gtd", 32'(if2.gated[0]), 32'h0);
    step_to(105); wake_req[1] = 1'b1;
    step_to(106); chk("rw_en106", 32'(if2.cg_en[1]), 32'h1);
                  rst = 1'b1;
    step_to(107); chk("rw_en",  32'(if2.cg_en), 32'hF);
                  chk("rw_ack", 32'(if2.wake_ack), 32'h0);
                  chk("rw_gtd", 32'(if2.gated), 32'h0);
                  rst = 1'b0; wake_req[1] = 1'b0;
`ifdef E603_CG_STATS_EN
    step_to(110); stats_clr = 1'b1;
    step_to(111); stats_clr = 1'b0;
                  chk("t6_clr", gcnt2[63:32], 32'd0);
`endif
    step_to(123); chk("rw_ch1_gtd", 32'(if2.gated[1]), 32'h1);
    step_to(140);
`ifdef E603_CG_STATS_EN
    chk("t6_gcnt17", gcnt2[63:32], 32'd17);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
